mmu09_clkgen: RTL and testbench
===============================

Name: mmu09_clkgen

Overview:
Clock, reset and timer-interrupt front end that sits directly upstream of the mmu09_sbc core. It divides the 4x master clock into the 6809 quadrature Q/E clocks and stretches and debounces reset into a clean reset_n. It also produces a periodic tick interrupt for the CPU. All outputs are registered and drive the SBC's qclk, eclk, reset_n and irq_n inputs directly.

Parameters:
RESET_ECYCLES, 4, number of complete E cycles that reset_n is held low after every reset source goes inactive (1..255)
DEBOUNCE_CLKS, 16, consecutive stable clk cycles required before the synchronised ext_reset changes its debounced state (2..65535)
TICK_ECYCLES, 1000, E cycles between tick interrupts (2..65535; only used when TICK_IRQ_EN is defined)

Ports:
clk        input   1   master clock, 4x E frequency; sole clock
reset      input   1   synchronous, active-high block reset
ext_reset  input   1   asynchronous reset button, active high, may bounce
irq_ack    input   1   CPU-side acknowledge that clears the tick interrupt; sampled on clk
qclk       output  1   6809 Q clock
eclk       output  1   6809 E clock
reset_n    output  1   CPU/SBC reset, active low
irq_n      output  1   tick interrupt to the SBC, active low
e_fall     output  1   one-clk strobe, high in the cycle after eclk falls

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state changes happen on posedge clk.
- While reset=1: phase=0, qclk=0, eclk=0, reset_n=0, irq_n=1, e_fall=0, sync/debounce regs=0, E counter=0, tick counter=0.
- Phase generator: 2-bit phase advances on every clk edge when reset=0 and wraps from 3 to 0. Edge action by current phase:
  - 0: qclk<=1
  - 1: eclk<=1
  - 2: qclk<=0
  - 3: eclk<=0, e_fall<=1 (otherwise e_fall<=0)
- Q leads E by exactly one clk. Period is 4 clk. The phase generator never stops, including while reset_n=0.
- ext_reset path:
  - 2-FF synchroniser, then debouncer.
  - A 16-bit counter counts while the synchronised value differs from the debounced value, and clears when they match.
  - The debounced value flips when the count reaches DEBOUNCE_CLKS.
  - A pulse shorter than DEBOUNCE_CLKS clk has no effect.
- Reset stretcher:
  - 8-bit E counter holds at 0 while reset_n=0 and debounced ext_reset=1.
  - Once debounced ext_reset=0 it increments on each phase-3 edge, saturating.
  - reset_n<=1 on the phase-3 edge at which the count reaches RESET_ECYCLES, so it rises coincident with eclk falling.
  - Debounced ext_reset=1 while reset_n=1 drives reset_n<=0 on the next edge, clears the E counter, and clears the tick counter.
- Timing from reset release: with defaults and ext_reset=0, the first edge with reset=0 is edge 0. reset_n goes high after edge 15 (16 clk).

Optional Feature:
TICK_IRQ_EN
- Defined:
  - 16-bit tick counter increments on phase-3 edges while reset_n=1.
  - On reaching TICK_ECYCLES-1 it wraps to 0 and sets irq_n<=0.
  - irq_n stays 0 until irq_ack=1 is sampled, then irq_n<=1.
  - If tick wrap and irq_ack occur on the same edge, irq_n stays 0 (the tick wins).
  - reset_n=0 forces irq_n<=1 and clears the counter.
- Undefined: no tick counter logic; irq_n is tied to 1; irq_ack is ignored.

Test Plan:
- Reset release: reset=1 for 3 clk, then 0, ext_reset=0.
  - qclk rises after edge 0; eclk after edge 1; qclk falls after edge 2; eclk falls after edge 3.
  - Pattern repeats with period 4 clk.
  - e_fall high only in the cycle after each eclk fall.
  - reset_n=0 through edge 14 and goes 1 after edge 15.
- Glitch rejection: after reset_n=1, pulse ext_reset high for 10 clk.
  - reset_n stays 1 and the phase pattern is undisturbed.
- Button press: hold ext_reset high for 40 clk starting at edge T.
  - reset_n goes 0 by edge T+2+16+1 and stays 0 while the button is held.
  - After release plus debounce (16 clk), reset_n rises on the 4th subsequent eclk fall.
- Tick (TICK_IRQ_EN, TICK_ECYCLES=10):
  - irq_n goes 0 on the 10th eclk fall after reset_n rises.
  - irq_ack pulse of 1 clk clears irq_n on the next edge.
  - Next assertion occurs 10 E cycles after the previous one.
- Ack collision (TICK_IRQ_EN): assert irq_ack on the exact edge of a tick wrap.
  - irq_n remains 0.
  - A later irq_ack clears it.
- Reset mid-operation: assert reset=1 for one clk while irq_n=0 and in phase 2.
  - Next cycle: qclk=0, eclk=0, reset_n=0, irq_n=1.
  - Restart sequence then matches the first scenario exactly.
- Macro off: build without TICK_IRQ_EN and run 5000 E cycles with irq_ack toggling.
  - irq_n is constant 1.

Source files
------------

// File: rtl/mmu09_clkgen_if.sv
// mmu09_clkgen front-end signal bundle.
// master = clock generator, slave = SBC side.
interface mmu09_clkgen_if;
  logic ext_reset;
  logic irq_ack;
  logic qclk;
  logic eclk;
  logic reset_n;
  logic irq_n;
  logic e_fall;

  modport master (
    input  ext_reset,
    input  irq_ack,
    output qclk,
    output eclk,
    output reset_n,
    output irq_n,
    output e_fall
  );

  modport slave (
    output ext_reset,
    output irq_ack,
    input  qclk,
    input  eclk,
    input  reset_n,
    input  irq_n,
    input  e_fall
  );
endinterface

// File: rtl/mmu09_clkgen.sv
// 6809 Q/E clock divider, reset stretcher/debouncer, tick irq.
// Define TICK_IRQ_EN to build the periodic tick interrupt.
module mmu09_clkgen #(
  parameter int RESET_ECYCLES = 4,
  parameter int DEBOUNCE_CLKS = 16,
  parameter int TICK_ECYCLES  = 1000
) (
  input  logic           clk,
  input  logic           reset,
  mmu09_clkgen_if.master bus
);

  typedef enum logic {
    RS_HOLD = 1'b0,
    RS_RUN  = 1'b1
  } rst_st_e;

  localparam logic [15:0] DB_LAST =
    16'(DEBOUNCE_CLKS - 1);
  localparam logic [7:0] RS_LAST =
    8'(RESET_ECYCLES);

  logic [1:0] phase;
  logic       ph3;
  logic       q_q;
  logic       e_q;
  logic       ef_q;

  assign ph3 = (phase == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 2'd0;
      q_q   <= 1'b0;
      e_q   <= 1'b0;
      ef_q  <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      ef_q  <= ph3;
      unique case (phase)
        2'd0: q_q <= 1'b1;
        2'd1: e_q <= 1'b1;
        2'd2: q_q <= 1'b0;
        2'd3: e_q <= 1'b0;
      endcase
    end
  end

  logic        sync1;
  logic        sync2;
  logic        deb;
  logic [15:0] dcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= 16'd0;
    end else begin
      sync1 <= bus.ext_reset;
      sync2 <= sync1;
      if (sync2 != deb) begin
        if (dcnt == DB_LAST) begin
          deb  <= sync2;
          dcnt <= 16'd0;
        end else begin
          dcnt <= dcnt + 16'd1;
        end
      end else begin
        dcnt <= 16'd0;
      end
    end
  end

  rst_st_e    st;
  rst_st_e    st_d;
  logic [7:0] ecnt;
  logic [7:0] ecnt_d;
  logic [7:0] ecnt_inc;

  assign ecnt_inc =
    (ecnt == 8'hff) ? ecnt : ecnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= RS_HOLD;
      ecnt <= 8'd0;
    end else begin
      st   <= st_d;
      ecnt <= ecnt_d;
    end
  end

  // release lands on a phase-3 edge so reset_n rises with E falling
  always_comb begin
    st_d   = st;
    ecnt_d = ecnt;
    unique case (st)
      RS_HOLD: begin
        if (deb) begin
          ecnt_d = 8'd0;
        end else if (ph3) begin
          ecnt_d = ecnt_inc;
          if (ecnt_inc >= RS_LAST)
            st_d = RS_RUN;
        end
      end
      RS_RUN: begin
        if (deb) begin
          st_d   = RS_HOLD;
          ecnt_d = 8'd0;
        end
      end
    endcase
  end

  assign bus.qclk    = q_q;
  assign bus.eclk    = e_q;
  assign bus.e_fall  = ef_q;
  assign bus.reset_n = (st == RS_RUN);

`ifdef TICK_IRQ_EN
  localparam logic [15:0] TK_LAST =
    16'(TICK_ECYCLES - 1);

  logic [15:0] tick;
  logic        irq_q;
  logic        drop;
  logic        wrap;

  assign drop = (st == RS_RUN) && deb;
  assign wrap = ph3 && (tick == TK_LAST);

  // a wrap on the same edge as an ack keeps irq_n low
  always_ff @(posedge clk) begin
    if (reset) begin
      tick  <= 16'd0;
      irq_q <= 1'b1;
    end else if (st == RS_HOLD) begin
      tick  <= 16'd0;
      irq_q <= 1'b1;
    end else begin
      if (drop)
        tick <= 16'd0;
      else if (ph3)
        tick <= wrap ? 16'd0 : tick + 16'd1;
      if (wrap && !drop)
        irq_q <= 1'b0;
      else if (bus.irq_ack)
        irq_q <= 1'b1;
    end
  end

  assign bus.irq_n = irq_q;
`else
  assign bus.irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_mmu09_clkgen.sv
// Randomized scoreboard bench for mmu09_clkgen.
// Model runs on edge counts; monitor checks every cycle.
module tb_mmu09_clkgen;

  localparam int R  = 4;
  localparam int D  = 16;
  localparam int TK = 10;

  logic clk;
  logic reset;

  mmu09_clkgen_if bus ();

  mmu09_clkgen #(
    .RESET_ECYCLES(R),
    .DEBOUNCE_CLKS(D),
    .TICK_ECYCLES (TK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [4:0] expq [$];

  // reference state: edge count, input history, run lengths
  int k;
  bit h1, h2;
  bit m_deb;
  int run;
  bit m_rn;
  int efalls;
  int ticks;
  bit m_irq;

  task automatic model_edge(input bit r,
                            input bit x,
                            input bit a);
    int  ph;
    bit  deb_pre;
    bit  rn_pre;
    bit  drop;
    bit  wrapped;
    if (r) begin
      k = 0; h1 = 0; h2 = 0; m_deb = 0; run = 0;
      m_rn = 0; efalls = 0; ticks = 0; m_irq = 1;
      expq.push_back(5'b00010);
      return;
    end
    ph      = k % 4;
    deb_pre = m_deb;
    rn_pre  = m_rn;
    drop    = rn_pre && deb_pre;
    if (h2 != m_deb) begin
      run++;
      if (run == D) begin
        m_deb = h2;
        run   = 0;
      end
    end else begin
      run = 0;
    end
    h2 = h1;
    h1 = x;
    if (!rn_pre) begin
      if (deb_pre) efalls = 0;
      else if (ph == 3) begin
        if (efalls < 255) efalls++;
        if (efalls >= R) m_rn = 1;
      end
    end else if (deb_pre) begin
      m_rn   = 0;
      efalls = 0;
    end
`ifdef TICK_IRQ_EN
    wrapped = 0;
    if (!rn_pre) begin
      ticks = 0;
      m_irq = 1;
    end else if (drop) begin
      ticks = 0;
      if (a) m_irq = 1;
    end else begin
      if (ph == 3) begin
        if (ticks == TK - 1) begin
          ticks   = 0;
          m_irq   = 0;
          wrapped = 1;
        end else begin
          ticks++;
        end
      end
      if (!wrapped && a) m_irq = 1;
    end
`else
    wrapped = a && drop;
    m_irq   = 1;
`endif
    k++;
    expq.push_back({ph < 2,
                    (ph == 1) || (ph == 2),
                    m_rn, m_irq, ph == 3});
  endtask

  task automatic step(input bit r,
                      input bit x,
                      input bit a);
    @(negedge clk);
    reset         = r;
    bus.ext_reset = x;
    bus.irq_ack   = a;
    @(posedge clk);
    model_edge(r, x, a);
  endtask

  function automatic bit rack();
    return ($urandom_range(0, 7) == 0);
  endfunction

  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] g;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g = {bus.qclk, bus.eclk, bus.reset_n,
           bus.irq_n, bus.e_fall};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outs cyc=%0d got q,e,rn,irq,ef=%b exp=%b",
                 cyc, g, e);
      end
    end
  end

  initial begin
    int lens [5];
    int len;
    int gap;
    reset         = 1'b1;
    bus.ext_reset = 1'b0;
    bus.irq_ack   = 1'b0;
    lens = '{15, 16, 17, 1, 40};

    repeat (3) step(1, 0, 0);
    repeat (40) step(0, 0, 0);

    repeat (10) step(0, 1, 0);
    repeat (40) step(0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      repeat (lens[i]) step(0, 1, rack());
      repeat (90) step(0, 0, rack());
    end

    repeat (30) begin
      len = $urandom_range(1, 24);
      gap = $urandom_range(1, 60);
      repeat (len) step(0, 1, rack());
      repeat (gap) step(0, 0, rack());
    end

    repeat (200) step(0, 0, 0);
    for (int i = 0; i < 4 && (k % 4) != 2; i++)
      step(0, 0, 0);
    step(1, 0, 0);
    repeat (60) step(0, 0, 0);

    for (int i = 0; i < 20000; i++)
      step(0, 0, ($urandom_range(0, 15) == 0));

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
